// File: rtl/scl_rep_in.sv
// Input-side pixel replicator: buffers a sparse pixel stream in a small FIFO and re-emits each pixel R = 1/2/4 times.
// Optional SCL_REP_OVF_CNT_EN adds scl_o_ovf_cnt, a saturating count of pixels dropped on a full FIFO.
module scl_rep_in #(
    parameter int DW = 24,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i_data_en,
    input  logic [DW-1:0] scl_i_data,
    input  logic          scl_cfg_mode,
    input  logic          scl_cfg_rsz,
    output logic          scl_o_data_en,
    output logic [DW-1:0] scl_o_data,
    output logic          scl_o_ovf,
`ifdef SCL_REP_OVF_CNT_EN
    output logic [7:0]    scl_o_ovf_cnt,
`endif
    output logic          scl_o_busy
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REP  = 1'b1
    } state_e;

    typedef struct packed {
        logic mode;
        logic rsz;
    } cfg_t;

    // Storage and pointers
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Replication control
    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    cfg_t          cfg_q, cfg_d;
    logic [1:0]    rep_m1;

    // Output registers
    logic [DW-1:0] data_q, data_d;
    logic          en_q, en_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          wr_acc;
    logic          drop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // Replication factor minus one, taken from the latched configuration only.
    assign rep_m1 = !cfg_q.mode ? 2'd0 : (cfg_q.rsz ? 2'd3 : 2'd1);

    // NOTE: every signal driven here gets a default first so no latch is inferred on any path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    en_d    = 1'b1;
                    cnt_d   = rep_m1;
                    state_d = ST_REP;
                end else begin
                    en_d = 1'b0;
                end
            end
            ST_REP: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                    en_d  = 1'b1;
                end else if (!fifo_empty) begin
                    // Back-to-back pop keeps the output enable continuous.
                    pop   = 1'b1;
                    cnt_d = rep_m1;
                    en_d  = 1'b1;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign wr_acc = scl_i_data_en && (!fifo_full || pop);
    assign drop   = scl_i_data_en && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            data_d   = mem_q[rd_ptr_q];
        end
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        cfg_d = cfg_q;
        if ((state_q == ST_IDLE) && fifo_empty) begin
            cfg_d = '{mode: scl_cfg_mode, rsz: scl_cfg_rsz};
        end
        ovf_d  = ovf_q | drop;
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            cfg_q    <= '0;
            data_q   <= '0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            data_q   <= data_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: the storage array has no reset; reset clears the pointers, which makes its contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= scl_i_data;
        end
    end

`ifdef SCL_REP_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= 8'd0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign scl_o_ovf_cnt = ovf_cnt_q;
`endif

    assign scl_o_data_en = en_q;
    assign scl_o_data    = data_q;
    assign scl_o_ovf     = ovf_q;
    assign scl_o_busy    = busy_q;

endmodule

// File: tb/tb_scl_rep_in.sv
// Directed bench for scl_rep_in: expected output pixels are queued when inputs are driven and checked as they appear.
module tb_scl_rep_in;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          scl_i_data_en;
    logic [DW-1:0] scl_i_data;
    logic          scl_cfg_mode;
    logic          scl_cfg_rsz;
    logic          scl_o_data_en;
    logic [DW-1:0] scl_o_data;
    logic          scl_o_ovf;
    logic          scl_o_busy;
`ifdef SCL_REP_OVF_CNT_EN
    logic [7:0]    scl_o_ovf_cnt;
`endif

    scl_rep_in #(.DW(DW), .AW(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .scl_i_data_en (scl_i_data_en),
        .scl_i_data    (scl_i_data),
        .scl_cfg_mode  (scl_cfg_mode),
        .scl_cfg_rsz   (scl_cfg_rsz),
        .scl_o_data_en (scl_o_data_en),
        .scl_o_data    (scl_o_data),
        .scl_o_ovf     (scl_o_ovf),
`ifdef SCL_REP_OVF_CNT_EN
        .scl_o_ovf_cnt (scl_o_ovf_cnt),
`endif
        .scl_o_busy    (scl_o_busy)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_px;
    int            en_cycles = 0;
    int            en_bursts = 0;
    logic          prev_en = 1'b0;

    // Output monitor: every valid output cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && scl_o_data_en) begin
            if (!prev_en) en_bursts++;
            en_cycles++;
            tests++;
            assert (sb_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out: observed data=%0h expected no output", scl_o_data);
            end
            if (sb_q.size() != 0) begin
                exp_px = sb_q.pop_front();
                tests++;
                assert (scl_o_data === exp_px) else begin
                    fails++;
                    $error("FAIL out_data: observed=%0h expected=%0h", scl_o_data, exp_px);
                end
            end
        end
        prev_en = rst ? scl_o_data_en : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one input cycle, let the edge pass, then settle 1 time unit past it.
    task automatic drive(input logic en, input logic [DW-1:0] d);
        scl_i_data_en = en;
        scl_i_data    = d;
        @(posedge clk);
        #1;
        scl_i_data_en = 1'b0;
        scl_i_data    = '0;
    endtask

    task automatic push(input logic [DW-1:0] d, input int r);
        repeat (r) sb_q.push_back(d);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((sb_q.size() != 0 || scl_o_busy) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_drain"}, 32'(k < 300), 32'd1);
        drive(1'b0, '0);
        check({tag, "_en_low"}, 32'(scl_o_data_en), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        scl_i_data_en = 1'b0;
        scl_i_data    = '0;
        scl_cfg_mode  = 1'b0;
        scl_cfg_rsz   = 1'b0;
        #12;
        check("rst_en",   32'(scl_o_data_en), 32'd0);
        check("rst_data", 32'(scl_o_data),    32'd0);
        check("rst_ovf",  32'(scl_o_ovf),     32'd0);
        check("rst_busy", 32'(scl_o_busy),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, '0);

        // Pass-through: 5 back-to-back pixels, 2-cycle latency.
        en_cycles = 0;
        en_bursts = 0;
        for (int i = 1; i <= 5; i++) begin
            push(DW'(i), 1);
            drive(1'b1, DW'(i));
            if (i == 1) check("t1_lat_early", 32'(scl_o_data_en), 32'd0);
            if (i == 2) begin
                check("t1_lat_en",   32'(scl_o_data_en), 32'd1);
                check("t1_lat_data", 32'(scl_o_data),    32'd1);
            end
        end
        drain("t1");
        check("t1_cycles", 32'(en_cycles), 32'd5);
        check("t1_bursts", 32'(en_bursts), 32'd1);
        check("t1_ovf",    32'(scl_o_ovf), 32'd0);

        // x2 replication with input every 2nd cycle: one continuous 6-cycle burst.
        scl_cfg_mode = 1'b1;
        scl_cfg_rsz  = 1'b0;
        en_cycles = 0;
        en_bursts = 0;
        for (int i = 0; i < 3; i++) begin
            push(DW'(24'hA0 + i), 2);
            drive(1'b1, DW'(24'hA0 + i));
            drive(1'b0, '0);
        end
        drain("t2");
        check("t2_cycles", 32'(en_cycles), 32'd6);
        check("t2_bursts", 32'(en_bursts), 32'd1);

        // Config change while busy is deferred until idle and empty.
        push(24'hB0, 2);
        drive(1'b1, 24'hB0);
        scl_cfg_rsz = 1'b1;
        check("t4_busy", 32'(scl_o_busy), 32'd1);
        drive(1'b0, '0);
        push(24'hB1, 2);
        drive(1'b1, 24'hB1);
        drain("t4a");
        push(24'hC0, 4);
        drive(1'b1, 24'hC0);
        drive(1'b0, '0);
        drive(1'b0, '0);
        drive(1'b0, '0);
        push(24'hC1, 4);
        drive(1'b1, 24'hC1);
        drain("t4b");
        check("t4_ovf", 32'(scl_o_ovf), 32'd0);

        // x4: fill to full exactly when a pop happens; the write must be accepted without overflow.
        for (int i = 0; i < 14; i++) begin
            if (i == 9 || i == 12) begin
                drive(1'b0, '0);
            end else begin
                push(DW'(24'h600 + i), 4);
                drive(1'b1, DW'(24'h600 + i));
            end
        end
        check("t6_ovf_full_pop", 32'(scl_o_ovf), 32'd0);
        drain("t6");
        check("t6_ovf_end", 32'(scl_o_ovf), 32'd0);

        // x4 with input every cycle: pixels 11, 12, 14, 15 are dropped.
        do_reset();
        check("t3_ovf_clear", 32'(scl_o_ovf), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i <= 10 || i == 13) push(DW'(24'h300 + i), 4);
            drive(1'b1, DW'(24'h300 + i));
            if (i == 10) check("t3_ovf_before", 32'(scl_o_ovf), 32'd0);
            if (i == 11) check("t3_ovf_set",    32'(scl_o_ovf), 32'd1);
        end
`ifdef SCL_REP_OVF_CNT_EN
        check("t3_ovf_cnt", 32'(scl_o_ovf_cnt), 32'd4);
`endif
        drain("t3");
        check("t3_ovf_sticky", 32'(scl_o_ovf), 32'd1);

        // Reset mid-replication with 3 pixels buffered.
        do_reset();
        push(24'h500, 4);
        for (int i = 0; i < 4; i++) drive(1'b1, DW'(24'h500 + i));
        check("t5_pre_en",   32'(scl_o_data_en), 32'd1);
        check("t5_pre_busy", 32'(scl_o_busy),    32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_en",   32'(scl_o_data_en), 32'd0);
        check("t5_rst_data", 32'(scl_o_data),    32'd0);
        check("t5_rst_busy", 32'(scl_o_busy),    32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en_cycles = 0;
        repeat (12) drive(1'b0, '0);
        check("t5_no_stale", 32'(en_cycles),  32'd0);
        check("t5_busy",     32'(scl_o_busy), 32'd0);
        check("t5_ovf",      32'(scl_o_ovf),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
